// File: rtl/bin8_to_bcd.sv
// 8-bit binary to 3-digit BCD converter using a serial double-dabble (shift-and-add-3) FSM.
// Optional leading-zero blanking flags are built only when BCD_BLANK_EN is defined.
module bin8_to_bcd (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       blank_h,
  output logic       blank_t,
  output logic [0:0] o_dbg_state
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  // Handshake: start is taken only in IDLE on a rising edge; busy is high for the 8
  // shift cycles that follow, then done pulses for one cycle with the new digits valid.
  logic [0:0]  r_state;
  logic [7:0]  r_shift;
  logic [11:0] r_scratch;
  logic [2:0]  r_count;
  logic        r_done;
  logic [3:0]  r_hundreds;
  logic [3:0]  r_tens;
  logic [3:0]  r_ones;

  logic [11:0] w_adj;
  logic [19:0] w_shifted;
  logic [11:0] w_next_scratch;
  logic [7:0]  w_next_shift;
  logic        w_last;

  // Scratch digits never exceed 9 here, so +3 stays within 4 bits.
  always_comb begin
    w_adj = r_scratch;
    for (int d = 0; d < 3; d++) begin
      if (r_scratch[d*4 +: 4] >= 4'd5) begin
        w_adj[d*4 +: 4] = r_scratch[d*4 +: 4] + 4'd3;
      end
    end
  end

  assign w_shifted      = {w_adj, r_shift} << 1;
  assign w_next_scratch = w_shifted[19:8];
  assign w_next_shift   = w_shifted[7:0];
  assign w_last         = (r_count == 3'd7);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_shift    <= 8'd0;
      r_scratch  <= 12'd0;
      r_count    <= 3'd0;
      r_done     <= 1'b0;
      r_hundreds <= 4'd0;
      r_tens     <= 4'd0;
      r_ones     <= 4'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift   <= bin;
            r_scratch <= 12'd0;
            r_count   <= 3'd0;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_scratch <= w_next_scratch;
          r_shift   <= w_next_shift;
          r_count   <= r_count + 3'd1;
          if (w_last) begin
            r_hundreds <= w_next_scratch[11:8];
            r_tens     <= w_next_scratch[7:4];
            r_ones     <= w_next_scratch[3:0];
            r_done     <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef BCD_BLANK_EN
  logic r_blank_h;
  logic r_blank_t;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blank_h <= 1'b0;
      r_blank_t <= 1'b0;
    end else if (r_state == S_SHIFT && w_last) begin
      r_blank_h <= (w_next_scratch[11:8] == 4'd0);
      r_blank_t <= (w_next_scratch[11:4] == 8'd0);
    end
  end

  assign blank_h = r_blank_h;
  assign blank_t = r_blank_t;
`else
  assign blank_h = 1'b0;
  assign blank_t = 1'b0;
`endif

  assign busy        = (r_state == S_SHIFT);
  assign done        = r_done;
  assign hundreds    = r_hundreds;
  assign tens        = r_tens;
  assign ones        = r_ones;
  assign o_dbg_state = r_state;

endmodule
